priority_arbiter_ctrl: RTL

PRIORITY_ARBITER_CTRL -- requirements
Module: priority_arbiter_ctrl

---
 rtl/priority_arbiter_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/priority_arbiter_ctrl.sv
// rtl/priority_arbiter_ctrl.sv - 16-way fixed/round-robin arbiter with hold timeout and release gap
module priority_arbiter_ctrl #(
    parameter logic [7:0] HOLD_MAX = 8'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        mode,
    input  logic        done,
    output logic        grant_valid,
    output logic [15:0] grant_onehot,
    output logic [7:0]  grant_code,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [3:0]  ptr, ptr_n;
    logic [7:0]  hold_cnt, hold_n;
    logic [3:0]  grant_id, id_n;
    logic        valid_n, timeout_n, busy_n;
    logic [15:0] onehot_n;
    logic [7:0]  code_n;

    logic [3:0]  fixed_win, rr_win, winner;
    logic        rr_found;
    logic        hold_at_max, owner_req, release_now;

    // Fixed priority: the last set bit seen in an ascending scan is the highest index.
    always_comb begin
        fixed_win = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (req[i]) begin
                fixed_win = 4'(i);
            end
        end
    end

    // Round-robin: first set bit at or after ptr, wrapping through 15 back to 0.
    always_comb begin
        logic [3:0] idx;
        rr_win   = ptr;
        rr_found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!rr_found && req[idx]) begin
                rr_win   = idx;
                rr_found = 1'b1;
            end
        end
    end

    assign winner      = mode ? rr_win : fixed_win;
    assign hold_at_max = (hold_cnt == HOLD_MAX);
    assign owner_req   = req[grant_id];
    assign release_now = done || !owner_req || hold_at_max;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        id_n      = grant_id;
        valid_n   = 1'b0;
        onehot_n  = 16'h0000;
        code_n    = 8'hF0;
        timeout_n = 1'b0;
        busy_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req != 16'h0000) begin
                    state_n  = ST_GRANT;
                    id_n     = winner;
                    hold_n   = 8'd1;
                    valid_n  = 1'b1;
                    onehot_n = 16'h0001 << winner;
                    code_n   = {4'b0000, winner};
                    busy_n   = 1'b1;
                end
            end
            ST_GRANT: begin
                busy_n = 1'b1;
                if (release_now) begin
                    state_n   = ST_RELEASE;
                    // A timeout is only flagged when nothing else explains the release.
                    timeout_n = hold_at_max && !done && owner_req;
                end else begin
                    hold_n   = hold_cnt + 8'd1;
                    valid_n  = 1'b1;
                    onehot_n = 16'h0001 << grant_id;
                    code_n   = {4'b0000, grant_id};
                end
            end
            ST_RELEASE: begin
                state_n = ST_IDLE;
                ptr_n   = grant_id + 4'd1;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= 4'd0;
            hold_cnt     <= 8'd0;
            grant_id     <= 4'd0;
            grant_valid  <= 1'b0;
            grant_onehot <= 16'h0000;
            grant_code   <= 8'hF0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            hold_cnt     <= hold_n;
            grant_id     <= id_n;
            grant_valid  <= valid_n;
            grant_onehot <= onehot_n;
            grant_code   <= code_n;
            timeout      <= timeout_n;
            busy         <= busy_n;
        end
    end

endmodule
